// File: rtl/stall_flush_ctrl_6stage.sv
// Hazard stall/flush controller for the 6-stage pipeline: load-use, multi-cycle E2 ops, E2 branch redirects.
// Define HAZ_PERF_EN to build the saturating hazard performance counters; otherwise the Perf* ports read 0.
module stall_flush_ctrl_6stage #(
   parameter int unsigned LOAD_USE_CYCLES = 2,
   parameter int unsigned CNT_W           = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReadE1,
   input  logic        MemReadE2,
   input  logic [4:0]  RD_E1,
   input  logic [4:0]  RD_E2,
   input  logic [4:0]  Rs1_D,
   input  logic [4:0]  Rs2_D,
   input  logic        UsesRs1_D,
   input  logic        UsesRs2_D,
   input  logic        BranchTakenE2,
   input  logic        MultiCycleE2,
   input  logic        McDoneE2,
   output logic        McStartE2,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE1,
   output logic        StallE2,
   output logic        FlushD,
   output logic        FlushE1,
   output logic        FlushM,
   output logic [31:0] PerfLdStall,
   output logic [31:0] PerfMcStall,
   output logic [31:0] PerfFlush
);

   typedef enum logic [1:0] {RUN, LD_STALL, MC_WAIT} state_t;

   localparam logic [CNT_W-1:0] LD_RELOAD = CNT_W'(LOAD_USE_CYCLES - 1);

   state_t           state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic             dep_e1, dep_e2;

   assign dep_e1 = MemReadE1 && (RD_E1 != 5'd0) &&
                   ((UsesRs1_D && (RD_E1 == Rs1_D)) || (UsesRs2_D && (RD_E1 == Rs2_D)));
   assign dep_e2 = MemReadE2 && (RD_E2 != 5'd0) &&
                   ((UsesRs1_D && (RD_E2 == Rs1_D)) || (UsesRs2_D && (RD_E2 == Rs2_D)));

   // Mealy outputs; everything is forced low while rst is high.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      McStartE2 = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE1   = 1'b0;
      StallE2   = 1'b0;
      FlushD    = 1'b0;
      FlushE1   = 1'b0;
      FlushM    = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               if (BranchTakenE2) begin
                  FlushD  = 1'b1;
                  FlushE1 = 1'b1;
               end else if (MultiCycleE2 && !McDoneE2) begin
                  McStartE2 = 1'b1;
                  StallF    = 1'b1;
                  StallD    = 1'b1;
                  StallE1   = 1'b1;
                  StallE2   = 1'b1;
                  FlushM    = 1'b1;
                  nxt_state = MC_WAIT;
               end else if (dep_e2) begin
                  StallF  = 1'b1;
                  StallD  = 1'b1;
                  FlushE1 = 1'b1;
               end else if (dep_e1) begin
                  StallF  = 1'b1;
                  StallD  = 1'b1;
                  FlushE1 = 1'b1;
                  if (LOAD_USE_CYCLES > 1) begin
                     nxt_cnt   = LD_RELOAD;
                     nxt_state = LD_STALL;
                  end
               end
            end
            LD_STALL: begin
               if (BranchTakenE2) begin
                  FlushD    = 1'b1;
                  FlushE1   = 1'b1;
                  nxt_cnt   = '0;
                  nxt_state = RUN;
               end else begin
                  StallF  = 1'b1;
                  StallD  = 1'b1;
                  FlushE1 = 1'b1;
                  nxt_cnt = cnt - CNT_W'(1);
                  if (cnt <= CNT_W'(1)) nxt_state = RUN;
               end
            end
            MC_WAIT: begin
               if (McDoneE2) begin
                  nxt_state = RUN;
               end else begin
                  StallF  = 1'b1;
                  StallD  = 1'b1;
                  StallE1 = 1'b1;
                  StallE2 = 1'b1;
                  FlushM  = 1'b1;
               end
            end
            default: nxt_state = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
      end
   end

`ifdef HAZ_PERF_EN
   // A load-use stall holds F/D but never E2, which separates it from a multi-cycle stall.
   logic ld_act;
   assign ld_act = StallD && !StallE2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PerfLdStall <= '0;
         PerfMcStall <= '0;
         PerfFlush   <= '0;
      end else begin
         if (ld_act && (PerfLdStall != '1)) PerfLdStall <= PerfLdStall + 32'd1;
         if ((state == MC_WAIT) && (PerfMcStall != '1)) PerfMcStall <= PerfMcStall + 32'd1;
         if (FlushD && (PerfFlush != '1)) PerfFlush <= PerfFlush + 32'd1;
      end
   end
`else
   assign PerfLdStall = '0;
   assign PerfMcStall = '0;
   assign PerfFlush   = '0;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl_6stage.sv
// Self-checking bench for stall_flush_ctrl_6stage: vector table, directed multi-cycle sequences, random vs. model.
module tb_stall_flush_ctrl_6stage;

   localparam int L = 2;

   logic clk = 1'b0;
   logic rst;
   logic MemReadE1, MemReadE2, UsesRs1_D, UsesRs2_D, BranchTakenE2, MultiCycleE2, McDoneE2;
   logic [4:0] RD_E1, RD_E2, Rs1_D, Rs2_D;
   logic McStartE2, StallF, StallD, StallE1, StallE2, FlushD, FlushE1, FlushM;
   logic [31:0] PerfLdStall, PerfMcStall, PerfFlush;

   always #5 clk = ~clk;

   stall_flush_ctrl_6stage #(.LOAD_USE_CYCLES(L), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .MemReadE1(MemReadE1), .MemReadE2(MemReadE2), .RD_E1(RD_E1), .RD_E2(RD_E2),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .UsesRs1_D(UsesRs1_D), .UsesRs2_D(UsesRs2_D),
      .BranchTakenE2(BranchTakenE2), .MultiCycleE2(MultiCycleE2), .McDoneE2(McDoneE2),
      .McStartE2(McStartE2), .StallF(StallF), .StallD(StallD), .StallE1(StallE1),
      .StallE2(StallE2), .FlushD(FlushD), .FlushE1(FlushE1), .FlushM(FlushM),
      .PerfLdStall(PerfLdStall), .PerfMcStall(PerfMcStall), .PerfFlush(PerfFlush)
   );

   // Expected output byte: {McStart, StallF, StallD, StallE1, StallE2, FlushD, FlushE1, FlushM}
   localparam logic [7:0] IDLE = 8'b0000_0000;
   localparam logic [7:0] LDST = 8'b0110_0010;
   localparam logic [7:0] BRFL = 8'b0000_0110;
   localparam logic [7:0] MCST = 8'b1111_1001;
   localparam logic [7:0] MCWT = 8'b0111_1001;

   int nvec = 0;
   int nmis = 0;

   typedef struct {
      logic       mre1, mre2, u1, u2, br, mc, done;
      logic [4:0] rde1, rde2, rs1, rs2;
      logic [7:0] exp;
   } vec_t;

   vec_t vt[15];

   // Reference model: remaining load-stall cycles, multi-cycle busy flag, perf tallies.
   int          m_ld_left;
   bit          m_mc;
   int unsigned m_pld, m_pmc, m_pfl;

   function automatic vec_t mk(logic mre1, logic [4:0] rde1, logic mre2, logic [4:0] rde2,
                               logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                               logic br, logic mc, logic done, logic [7:0] exp);
      vec_t v;
      v.mre1 = mre1; v.rde1 = rde1; v.mre2 = mre2; v.rde2 = rde2;
      v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.br = br; v.mc = mc; v.done = done; v.exp = exp;
      return v;
   endfunction

   function automatic logic reads(input logic mr, input logic [4:0] rd);
      return mr && (rd != 5'd0) && ((UsesRs1_D && rd == Rs1_D) || (UsesRs2_D && rd == Rs2_D));
   endfunction

   task automatic idle_inputs();
      MemReadE1 = 0; MemReadE2 = 0; RD_E1 = 0; RD_E2 = 0; Rs1_D = 0; Rs2_D = 0;
      UsesRs1_D = 0; UsesRs2_D = 0; BranchTakenE2 = 0; MultiCycleE2 = 0; McDoneE2 = 0;
   endtask

   task automatic apply(input vec_t v);
      MemReadE1 = v.mre1; RD_E1 = v.rde1; MemReadE2 = v.mre2; RD_E2 = v.rde2;
      Rs1_D = v.rs1; UsesRs1_D = v.u1; Rs2_D = v.rs2; UsesRs2_D = v.u2;
      BranchTakenE2 = v.br; MultiCycleE2 = v.mc; McDoneE2 = v.done;
   endtask

   task automatic check(input string name, input logic [7:0] exp);
      logic [7:0] act;
      act = {McStartE2, StallF, StallD, StallE1, StallE2, FlushD, FlushE1, FlushM};
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Entered and left at posedge+1; outputs are checked at the negedge.
   task automatic cyc(input string name, input logic [7:0] exp);
      @(negedge clk);
      check(name, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      check("reset_outputs", IDLE);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic model_step(output logic [7:0] e);
      e = IDLE;
      if (rst) begin
         m_ld_left = 0; m_mc = 0; m_pld = 0; m_pmc = 0; m_pfl = 0;
         return;
      end
      if (m_mc) begin
         m_pmc++;
         if (McDoneE2) m_mc = 0;
         else e = MCWT;
      end else if (m_ld_left > 0) begin
         if (BranchTakenE2) begin e = BRFL; m_ld_left = 0; end
         else begin e = LDST; m_ld_left--; end
      end else if (BranchTakenE2) e = BRFL;
      else if (MultiCycleE2 && !McDoneE2) begin e = MCST; m_mc = 1; end
      else if (reads(MemReadE2, RD_E2)) e = LDST;
      else if (reads(MemReadE1, RD_E1)) begin e = LDST; m_ld_left = L - 1; end
      if (e[5] && !e[3]) m_pld++;
      if (e[2]) m_pfl++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] e;
      idle_inputs();
      rst = 1'b0;
      #1;
      do_reset();

      // Single-cycle decisions from RUN; each vector is followed by a reset back to RUN.
      vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
      vt[1]  = mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, LDST);
      vt[2]  = mk(1, 9, 0, 0, 3, 1, 9, 1, 0, 0, 0, LDST);
      vt[3]  = mk(1, 5, 0, 0, 5, 0, 0, 0, 0, 0, 0, IDLE);
      vt[4]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, IDLE);
      vt[5]  = mk(0, 0, 1, 7, 0, 0, 7, 1, 0, 0, 0, LDST);
      vt[6]  = mk(0, 0, 1, 7, 0, 0, 7, 0, 0, 0, 0, IDLE);
      vt[7]  = mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, IDLE);
      vt[8]  = mk(0, 5, 0, 7, 5, 1, 7, 1, 0, 0, 0, IDLE);
      vt[9]  = mk(1, 5, 0, 0, 5, 1, 0, 0, 1, 0, 0, BRFL);
      vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MCST);
      vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE);
      vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, BRFL);
      vt[13] = mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 1, 0, MCST);
      vt[14] = mk(1, 4, 1, 6, 4, 1, 6, 1, 0, 0, 0, LDST);
      for (int i = 0; i < 15; i++) begin
         apply(vt[i]);
         @(negedge clk);
         check($sformatf("vec%0d", i), vt[i].exp);
         do_reset();
      end

      // Load in E1 feeding D: exactly L stall cycles.
      apply(vt[1]);
      cyc("ldE1_c0", LDST);
      idle_inputs();
      cyc("ldE1_c1", LDST);
      cyc("ldE1_after", IDLE);

      // Load in E2 feeding D: one stall cycle.
      apply(vt[5]);
      cyc("ldE2_c0", LDST);
      idle_inputs();
      cyc("ldE2_after", IDLE);

      // Multi-cycle op completing 5 cycles after start.
      MultiCycleE2 = 1;
      cyc("mc_start", MCST);
      for (int i = 1; i < 5; i++) cyc($sformatf("mc_wait%0d", i), MCWT);
      McDoneE2 = 1;
      cyc("mc_done", IDLE);
      idle_inputs();
      cyc("mc_after", IDLE);

      // Branch together with a load-use dependency.
      apply(vt[9]);
      cyc("br_dep", BRFL);
      idle_inputs();
      cyc("br_after", IDLE);

      // Branch arriving during a load stall cancels the remaining stall.
      apply(vt[1]);
      cyc("ldbr_c0", LDST);
      idle_inputs();
      BranchTakenE2 = 1;
      cyc("ldbr_flush", BRFL);
      idle_inputs();
      cyc("ldbr_after", IDLE);

      // Reset in the middle of a multi-cycle wait.
      MultiCycleE2 = 1;
      cyc("mcrst_start", MCST);
      cyc("mcrst_wait", MCWT);
      rst = 1'b1;
      #1;
      check("mcrst_async", IDLE);
      @(posedge clk);
      #1;
      rst = 1'b0;
      MultiCycleE2 = 0;
      cyc("mcrst_after", IDLE);

      // Performance counters: one 2-cycle load stall plus one branch.
      do_reset();
      apply(vt[1]);
      cyc("perf_ld0", LDST);
      idle_inputs();
      cyc("perf_ld1", LDST);
      cyc("perf_idle", IDLE);
      BranchTakenE2 = 1;
      cyc("perf_br", BRFL);
      idle_inputs();
      cyc("perf_end", IDLE);
`ifdef HAZ_PERF_EN
      check32("perf_ld", PerfLdStall, 32'd2);
      check32("perf_mc", PerfMcStall, 32'd0);
      check32("perf_fl", PerfFlush, 32'd1);
`else
      check32("perf_ld_tied", PerfLdStall, 32'd0);
      check32("perf_mc_tied", PerfMcStall, 32'd0);
      check32("perf_fl_tied", PerfFlush, 32'd0);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      m_ld_left = 0; m_mc = 0; m_pld = 0; m_pmc = 0; m_pfl = 0;
      for (int n = 0; n < 3000; n++) begin
         rst           = ($urandom_range(0, 149) == 0);
         MemReadE1     = $urandom_range(0, 1);
         MemReadE2     = $urandom_range(0, 1);
         RD_E1         = 5'($urandom_range(0, 3));
         RD_E2         = 5'($urandom_range(0, 3));
         Rs1_D         = 5'($urandom_range(0, 3));
         Rs2_D         = 5'($urandom_range(0, 3));
         UsesRs1_D     = $urandom_range(0, 1);
         UsesRs2_D     = $urandom_range(0, 1);
         BranchTakenE2 = ($urandom_range(0, 7) == 0);
         MultiCycleE2  = ($urandom_range(0, 5) == 0);
         McDoneE2      = ($urandom_range(0, 2) == 0);
         @(negedge clk);
         model_step(e);
         check("rand", e);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      idle_inputs();
`ifdef HAZ_PERF_EN
      check32("rand_perf_ld", PerfLdStall, m_pld);
      check32("rand_perf_mc", PerfMcStall, m_pmc);
      check32("rand_perf_fl", PerfFlush, m_pfl);
`else
      check32("rand_perf_ld_tied", PerfLdStall, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
